// File: rtl/layer_seq_pkg.sv
// Shared definitions for layer_sequencer: engine opcodes, FSM states
// and header field positions.
package layer_seq_pkg;

    localparam logic [2:0] OP_CONV2D  = 3'd1;
    localparam logic [2:0] OP_CHADD   = 3'd2;
    localparam logic [2:0] OP_MAXPOOL = 3'd3;
    localparam logic [2:0] OP_RELU    = 3'd4;

    localparam int HDR_OP_LSB = 0;
    localparam int HDR_OP_W   = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_STREAM,
        ST_DISCARD
    } state_e;

endpackage

// File: rtl/stream_mux_n.sv
// Return-path mux: selects one engine result stream onto the master port
// and steers the master ready back to that engine only.
module stream_mux_n #(
    parameter int NUM_ENG = 4,
    parameter int DATA_W  = 32,
    parameter int SEL_W   = 2
) (
    input  logic [SEL_W-1:0]          sel,
    input  logic                      en,
    input  logic [NUM_ENG*DATA_W-1:0] ret_tdata,
    input  logic [NUM_ENG*2-1:0]      ret_tkeep,
    input  logic [NUM_ENG-1:0]        ret_tlast,
    input  logic [NUM_ENG-1:0]        ret_tvalid,
    output logic [NUM_ENG-1:0]        ret_tready,
    output logic [DATA_W-1:0]         m_tdata,
    output logic [1:0]                m_tkeep,
    output logic                      m_tlast,
    output logic                      m_tvalid,
    input  logic                      m_tready
);

    always_comb begin
        m_tdata    = '0;
        m_tkeep    = '0;
        m_tlast    = 1'b0;
        m_tvalid   = 1'b0;
        ret_tready = '0;
        for (int i = 0; i < NUM_ENG; i++) begin
            if (sel == SEL_W'(i)) begin
                m_tdata       = ret_tdata[i*DATA_W +: DATA_W];
                m_tkeep       = ret_tkeep[i*2 +: 2];
                m_tlast       = ret_tlast[i];
                m_tvalid      = ret_tvalid[i] & en;
                ret_tready[i] = m_tready & en;
            end
        end
    end

endmodule

// File: rtl/layer_sequencer.sv
// Header-driven front end for the layer engines. Define
// LAYER_SEQ_TIMEOUT_EN to add the stalled-stream watchdog.
module layer_sequencer
    import layer_seq_pkg::*;
#(
    parameter int NUM_ENG = 4,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                      S_AXIS_ACLK,
    input  logic                      S_AXIS_ARESETN,
    input  logic [DATA_W-1:0]         S_AXIS_TDATA,
    input  logic [1:0]                S_AXIS_TKEEP,
    input  logic                      S_AXIS_TLAST,
    input  logic                      S_AXIS_TVALID,
    output logic                      S_AXIS_TREADY,
    output logic [DATA_W-1:0]         M_AXIS_TDATA,
    output logic [1:0]                M_AXIS_TKEEP,
    output logic                      M_AXIS_TLAST,
    output logic                      M_AXIS_TVALID,
    input  logic                      M_AXIS_TREADY,
    output logic [DATA_W-1:0]         eng_tdata,
    output logic [1:0]                eng_tkeep,
    output logic                      eng_tlast,
    output logic [NUM_ENG-1:0]        eng_tvalid,
    input  logic [NUM_ENG-1:0]        eng_tready,
    input  logic [NUM_ENG*DATA_W-1:0] ret_tdata,
    input  logic [NUM_ENG*2-1:0]      ret_tkeep,
    input  logic [NUM_ENG-1:0]        ret_tlast,
    input  logic [NUM_ENG-1:0]        ret_tvalid,
    output logic [NUM_ENG-1:0]        ret_tready,
    output logic [NUM_ENG-1:0]        eng_resetn,
    output logic                      busy,
    output logic [2:0]                cur_op,
    output logic [CNT_W-1:0]          out_beats,
    output logic                      err_bad_op,
    output logic                      err_timeout
);

    localparam int SEL_W = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam logic [HDR_OP_W-1:0] OP_MAX = HDR_OP_W'(NUM_ENG);

    state_e              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [HDR_OP_W-1:0] op_q, op_d;
    logic                in_done_q, in_done_d;
    logic                out_done_q, out_done_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0]    out_beats_q, out_beats_d;
    logic                err_bad_op_q, err_bad_op_d;
    logic                run_q;

    logic [NUM_ENG-1:0]  sel_oh;
    logic [HDR_OP_W-1:0] hdr_op;
    logic                op_ok, s_rdy, s_fire, m_fire, ret_en;

`ifdef LAYER_SEQ_TIMEOUT_EN
    logic [CNT_W-1:0]    wd_q, wd_d;
    logic                err_timeout_q, err_timeout_d;
`endif

    assign sel_oh = NUM_ENG'(1) << sel_q;
    assign hdr_op = S_AXIS_TDATA[HDR_OP_LSB +: HDR_OP_W];
    assign op_ok  = (hdr_op >= OP_CONV2D) && (hdr_op <= OP_MAX);
    assign ret_en = (state_q == ST_STREAM) && !out_done_q;

    assign eng_tdata = S_AXIS_TDATA;
    assign eng_tkeep = S_AXIS_TKEEP;
    assign eng_tlast = S_AXIS_TLAST;

    stream_mux_n #(
        .NUM_ENG (NUM_ENG),
        .DATA_W  (DATA_W),
        .SEL_W   (SEL_W)
    ) u_ret_mux (
        .sel        (sel_q),
        .en         (ret_en),
        .ret_tdata  (ret_tdata),
        .ret_tkeep  (ret_tkeep),
        .ret_tlast  (ret_tlast),
        .ret_tvalid (ret_tvalid),
        .ret_tready (ret_tready),
        .m_tdata    (M_AXIS_TDATA),
        .m_tkeep    (M_AXIS_TKEEP),
        .m_tlast    (M_AXIS_TLAST),
        .m_tvalid   (M_AXIS_TVALID),
        .m_tready   (M_AXIS_TREADY)
    );

    // run_q keeps IDLE from advertising ready while reset is asserted
    always_comb begin
        s_rdy = 1'b0;
        unique case (state_q)
            ST_IDLE:    s_rdy = run_q;
            ST_STREAM:  s_rdy = |(eng_tready & sel_oh) & ~in_done_q;
            ST_DISCARD: s_rdy = 1'b1;
            default:    s_rdy = 1'b0;
        endcase
    end

    assign S_AXIS_TREADY = s_rdy;
    assign s_fire        = S_AXIS_TVALID & s_rdy;
    assign m_fire        = M_AXIS_TVALID & M_AXIS_TREADY;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        op_d         = op_q;
        in_done_d    = in_done_q;
        out_done_d   = out_done_q;
        cnt_d        = cnt_q;
        out_beats_d  = out_beats_q;
        err_bad_op_d = 1'b0;
        eng_tvalid   = '0;
        eng_resetn   = '0;
`ifdef LAYER_SEQ_TIMEOUT_EN
        wd_d          = wd_q;
        err_timeout_d = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (s_fire) begin
                    if (S_AXIS_TLAST) begin
                        err_bad_op_d = 1'b1;
                    end else if (op_ok) begin
                        sel_d   = SEL_W'(hdr_op - OP_CONV2D);
                        op_d    = hdr_op;
                        state_d = ST_CLEAR;
                    end else begin
                        err_bad_op_d = 1'b1;
                        state_d      = ST_DISCARD;
                    end
                end
            end
            ST_CLEAR: begin
                in_done_d  = 1'b0;
                out_done_d = 1'b0;
                cnt_d      = '0;
                state_d    = ST_STREAM;
`ifdef LAYER_SEQ_TIMEOUT_EN
                wd_d       = '0;
`endif
            end
            ST_STREAM: begin
                eng_resetn = sel_oh;
                if (S_AXIS_TVALID && !in_done_q) begin
                    eng_tvalid = sel_oh;
                end
                if (s_fire && S_AXIS_TLAST) begin
                    in_done_d = 1'b1;
                end
                if (m_fire) begin
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    if (M_AXIS_TLAST) begin
                        out_done_d  = 1'b1;
                        out_beats_d = cnt_d;
                    end
                end
                if (in_done_d && out_done_d) begin
                    state_d = ST_IDLE;
                    op_d    = '0;
                end
`ifdef LAYER_SEQ_TIMEOUT_EN
                if (s_fire || m_fire) begin
                    wd_d = '0;
                end else begin
                    wd_d = wd_q + 1'b1;
                    if (wd_d == '1) begin
                        err_timeout_d = 1'b1;
                        op_d          = '0;
                        state_d       = in_done_d ? ST_IDLE : ST_DISCARD;
                    end
                end
`endif
            end
            ST_DISCARD: begin
                if (s_fire && S_AXIS_TLAST) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state_q      <= ST_IDLE;
            sel_q        <= '0;
            op_q         <= '0;
            in_done_q    <= 1'b0;
            out_done_q   <= 1'b0;
            cnt_q        <= '0;
            out_beats_q  <= '0;
            err_bad_op_q <= 1'b0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            op_q         <= op_d;
            in_done_q    <= in_done_d;
            out_done_q   <= out_done_d;
            cnt_q        <= cnt_d;
            out_beats_q  <= out_beats_d;
            err_bad_op_q <= err_bad_op_d;
            run_q        <= 1'b1;
        end
    end

`ifdef LAYER_SEQ_TIMEOUT_EN
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            wd_q          <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            err_timeout_q <= err_timeout_d;
        end
    end

    assign err_timeout = err_timeout_q;
`else
    assign err_timeout = 1'b0;
`endif

    assign busy       = (state_q != ST_IDLE);
    assign cur_op     = op_q;
    assign out_beats  = out_beats_q;
    assign err_bad_op = err_bad_op_q;

endmodule

// File: tb/tb_layer_sequencer.sv
// Directed bench for layer_sequencer: header decode, feed/return routing,
// error packets, mid-packet reset and (with LAYER_SEQ_TIMEOUT_EN) the watchdog.
module tb_layer_sequencer;

    localparam int NE = 4;
    localparam int DW = 32;
`ifdef LAYER_SEQ_TIMEOUT_EN
    localparam int CW = 4;
`else
    localparam int CW = 16;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic [DW-1:0]     s_tdata;
    logic [1:0]        s_tkeep;
    logic              s_tlast, s_tvalid, s_tready;
    logic [DW-1:0]     m_tdata;
    logic [1:0]        m_tkeep;
    logic              m_tlast, m_tvalid, m_tready;
    logic [DW-1:0]     e_tdata;
    logic [1:0]        e_tkeep;
    logic              e_tlast;
    logic [NE-1:0]     e_tvalid, e_tready;
    logic [NE*DW-1:0]  r_tdata;
    logic [NE*2-1:0]   r_tkeep;
    logic [NE-1:0]     r_tlast, r_tvalid, r_tready;
    logic [NE-1:0]     e_resetn;
    logic              busy;
    logic [2:0]        cur_op;
    logic [CW-1:0]     out_beats;
    logic              err_bad_op, err_timeout;

    layer_sequencer #(.NUM_ENG(NE), .DATA_W(DW), .CNT_W(CW)) dut (
        .S_AXIS_ACLK    (clk),
        .S_AXIS_ARESETN (rst_n),
        .S_AXIS_TDATA   (s_tdata),
        .S_AXIS_TKEEP   (s_tkeep),
        .S_AXIS_TLAST   (s_tlast),
        .S_AXIS_TVALID  (s_tvalid),
        .S_AXIS_TREADY  (s_tready),
        .M_AXIS_TDATA   (m_tdata),
        .M_AXIS_TKEEP   (m_tkeep),
        .M_AXIS_TLAST   (m_tlast),
        .M_AXIS_TVALID  (m_tvalid),
        .M_AXIS_TREADY  (m_tready),
        .eng_tdata      (e_tdata),
        .eng_tkeep      (e_tkeep),
        .eng_tlast      (e_tlast),
        .eng_tvalid     (e_tvalid),
        .eng_tready     (e_tready),
        .ret_tdata      (r_tdata),
        .ret_tkeep      (r_tkeep),
        .ret_tlast      (r_tlast),
        .ret_tvalid     (r_tvalid),
        .ret_tready     (r_tready),
        .eng_resetn     (e_resetn),
        .busy           (busy),
        .cur_op         (cur_op),
        .out_beats      (out_beats),
        .err_bad_op     (err_bad_op),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    int vec = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        vec++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    // monitor state, cleared per scenario
    int        feed_beats, feed_err, m_beats, m_err, m_after_last;
    int        bad_ops, tmos, vld_cnt, clr_cyc, busy_nrdy, rstn_hi;
    logic      m_last_seen;
    logic [NE-1:0] rstn_or;
    logic [2:0]    op_or;
    int        exp_eng;
    logic      m_stall = 1'b0;

    task automatic clr_mon();
        feed_beats = 0; feed_err = 0; m_beats = 0; m_err = 0;
        m_after_last = 0; bad_ops = 0; tmos = 0; vld_cnt = 0;
        clr_cyc = 0; busy_nrdy = 0; rstn_hi = 0;
        m_last_seen = 1'b0; rstn_or = '0; op_or = '0;
    endtask

    always @(negedge clk) begin
        m_tready = m_stall ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        #1;
        if (|(e_tvalid & e_tready)) begin
            if (e_tdata !== 32'hD000_0000 + 32'(feed_beats)) feed_err++;
            feed_beats++;
        end
        if (m_tvalid && m_last_seen) m_after_last++;
        if (m_tvalid && m_tready) begin
            if (m_tdata !== (32'hE000_0000 | (32'(exp_eng) << 16) | 32'(m_beats)))
                m_err++;
            m_beats++;
            if (m_tlast) m_last_seen = 1'b1;
        end
        if (err_bad_op) bad_ops++;
        if (err_timeout) tmos++;
        if (|e_tvalid) vld_cnt++;
        if (busy && e_resetn == '0) clr_cyc++;
        if (busy && !s_tready) busy_nrdy++;
        if (|e_resetn) rstn_hi++;
        rstn_or = rstn_or | e_resetn;
        if (busy) op_or = op_or | cur_op;
    end

    task automatic s_beat(input logic [31:0] d, input logic last, input int gap);
        repeat (gap) begin
            @(negedge clk);
            s_tvalid = 1'b0;
        end
        @(negedge clk);
        s_tdata = d; s_tlast = last; s_tvalid = 1'b1; s_tkeep = 2'b11;
        #1;
        for (int t = 0; t < 200 && !s_tready; t++) begin
            @(negedge clk);
            #1;
        end
        if (!s_tready) check("s_ready_wait", 64'(s_tready), 64'd1);
        @(posedge clk);
    endtask

    task automatic send_pkt(input logic [31:0] hdr, input int n, input int maxgap);
        s_beat(hdr, n == 0, 0);
        for (int i = 0; i < n; i++)
            s_beat(32'hD000_0000 + 32'(i), i == n - 1,
                   maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0);
        @(negedge clk);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic ret_pkt(input int e, input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            repeat (maxgap > 0 ? int'($urandom_range(0, maxgap)) : 0) begin
                @(negedge clk);
                r_tvalid[e] = 1'b0;
            end
            @(negedge clk);
            r_tdata[e*DW +: DW] = 32'hE000_0000 | (32'(e) << 16) | 32'(i);
            r_tkeep[e*2 +: 2]   = 2'b11;
            r_tlast[e]          = (i == n - 1);
            r_tvalid[e]         = 1'b1;
            #1;
            for (int t = 0; t < 200 && !r_tready[e]; t++) begin
                @(negedge clk);
                #1;
            end
            if (!r_tready[e]) check("ret_ready_wait", 64'(r_tready[e]), 64'd1);
            @(posedge clk);
        end
        @(negedge clk);
        r_tvalid[e] = 1'b0;
        r_tlast[e]  = 1'b0;
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
        #2;
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

    initial begin
        logic busy_mid;
        rst_n = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0; s_tvalid = 1'b0;
        e_tready = '1; r_tdata = '0; r_tkeep = '0; r_tlast = '0; r_tvalid = '0;
        exp_eng = 0;
        clr_mon();
        s_tvalid = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("rst_tready", 64'(s_tready), 64'd0);
        check("rst_busy_op", 64'({busy, cur_op}), 64'd0);
        check("rst_eng", 64'({e_resetn, e_tvalid, r_tready}), 64'd0);
        check("rst_m_valid", 64'(m_tvalid), 64'd0);
        check("rst_beats_err", 64'({out_beats, err_bad_op, err_timeout}), 64'd0);
        s_tvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // op 1: 9 feed beats, 4 result beats
        clr_mon(); exp_eng = 0;
        fork
            send_pkt(32'h1, 9, 0);
            ret_pkt(0, 4, 0);
        join
        #1;
        check("t1_busy_end", 64'(busy), 64'd0);
        settle();
        check("t1_clear_cyc", 64'(clr_cyc), 64'd1);
        check("t1_feed_beats", 64'(feed_beats), 64'd9);
        check("t1_m_beats", 64'(m_beats), 64'd4);
        check("t1_out_beats", 64'(out_beats), 64'd4);
        check("t1_data_err", 64'(feed_err + m_err), 64'd0);
        check("t1_rstn_sel", 64'(rstn_or), 64'b0001);
        check("t1_cur_op", 64'(op_or), 64'd1);

        // illegal op 7 followed by 3 dropped beats
        clr_mon();
        send_pkt(32'h7, 3, 0);
        settle();
        check("t2_bad_op", 64'(bad_ops), 64'd1);
        check("t2_no_eng_vld", 64'(vld_cnt), 64'd0);
        check("t2_tready_hi", 64'(busy_nrdy), 64'd0);
        check("t2_busy", 64'(busy), 64'd0);
        check("t2_out_beats_kept", 64'(out_beats), 64'd4);

        // op 5 is one past the last engine
        clr_mon();
        send_pkt(32'h5, 1, 0);
        settle();
        check("t2b_bad_op", 64'(bad_ops), 64'd1);
        check("t2b_no_rstn", 64'(rstn_hi), 64'd0);

        // header-only packet with a legal opcode
        clr_mon();
        send_pkt(32'h4, 0, 0);
        settle();
        check("t3_bad_op", 64'(bad_ops), 64'd1);
        check("t3_busy", 64'(busy), 64'd0);
        check("t3_rstn", 64'(rstn_hi), 64'd0);
        check("t3_clr", 64'(clr_cyc), 64'd0);

        // op 4 selects the last engine
        clr_mon(); exp_eng = 3;
        fork
            send_pkt(32'h4, 2, 0);
            ret_pkt(3, 1, 0);
        join
        settle();
        check("t3b_rstn_sel", 64'(rstn_or), 64'b1000);
        check("t3b_cur_op", 64'(op_or), 64'd4);
        check("t3b_out_beats", 64'(out_beats), 64'd1);
        check("t3b_feed", 64'(feed_beats), 64'd2);

        // engine 2 result finishes first, both sides stalled
        clr_mon(); exp_eng = 2; m_stall = 1'b1; busy_mid = 1'b0;
        fork
            send_pkt(32'h3, 14, 2);
            begin
                ret_pkt(2, 3, 1);
                @(negedge clk);
                r_tdata[2*DW +: DW] = 32'hBAD0_BAD0;
                r_tvalid[2] = 1'b1;
                #1;
                busy_mid = busy;
            end
        join
        @(negedge clk);
        r_tvalid[2] = 1'b0;
        m_stall = 1'b0;
        settle();
        check("t4_busy_mid", 64'(busy_mid), 64'd1);
        check("t4_feed_beats", 64'(feed_beats), 64'd14);
        check("t4_m_beats", 64'(m_beats), 64'd3);
        check("t4_after_last", 64'(m_after_last), 64'd0);
        check("t4_data_err", 64'(feed_err + m_err), 64'd0);
        check("t4_out_beats", 64'(out_beats), 64'd3);
        check("t4_busy", 64'(busy), 64'd0);

        // reset asserted in the middle of a stream
        clr_mon(); exp_eng = 2;
        s_beat(32'h3, 1'b0, 0);
        s_beat(32'hD000_0000, 1'b0, 0);
        @(negedge clk);
        r_tdata[2*DW +: DW] = 32'hE002_0000;
        r_tlast[2] = 1'b0;
        r_tvalid[2] = 1'b1;
        #2;
        check("t5_pre_m_valid", 64'(m_tvalid), 64'd1);
        check("t5_pre_rstn", 64'(e_resetn), 64'b0100);
        rst_n = 1'b0;
        #1;
        check("t5_busy_op", 64'({busy, cur_op}), 64'd0);
        check("t5_eng", 64'({e_resetn, e_tvalid, r_tready}), 64'd0);
        check("t5_s_m", 64'({s_tready, m_tvalid}), 64'd0);
        check("t5_beats", 64'(out_beats), 64'd0);
        @(negedge clk);
        s_tvalid = 1'b0; s_tlast = 1'b0; r_tvalid = '0; r_tlast = '0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        clr_mon(); exp_eng = 2;
        fork
            send_pkt(32'h3, 2, 0);
            ret_pkt(2, 2, 0);
        join
        settle();
        check("t5_post_out", 64'(out_beats), 64'd2);
        check("t5_post_feed", 64'(feed_beats), 64'd2);
        check("t5_post_err", 64'(feed_err + m_err + bad_ops), 64'd0);
        check("t5_post_busy", 64'(busy), 64'd0);

`ifdef LAYER_SEQ_TIMEOUT_EN
        // engine never ready: watchdog aborts, rest of packet drained
        clr_mon();
        e_tready = '0;
        send_pkt(32'h1, 5, 0);
        settle();
        e_tready = '1;
        check("t6_timeout", 64'(tmos), 64'd1);
        check("t6_stream_cyc", 64'(rstn_hi), 64'd15);
        check("t6_feed", 64'(feed_beats), 64'd0);
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_bad_op", 64'(bad_ops), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
        $finish;
    end

endmodule

// File: doc/layer_sequencer.md
Name: layer_sequencer

Overview:
- Front-end controller for the accelerator's layer engines (conv2d, channel_add, maxpool, relu).
- Parses a header word at the start of each DMA stream packet and selects one engine.
- Pulses that engine's reset, then routes the packet to it and its result stream back to DRAM.
- Returns to idle once both directions have seen TLAST. Replaces ad-hoc state selection in the accelerator top.

Parameters:
- NUM_ENG, 4, number of engines; opcode n (1..NUM_ENG) selects engine n-1.
- DATA_W, 32, stream data width.
- CNT_W, 16, width of beat counters and timeout counter.

Ports:
- S_AXIS_ACLK  in  1  single clock for all logic.
- S_AXIS_ARESETN  in  1  asynchronous, active-low reset.
- S_AXIS_TDATA/TKEEP/TLAST/TVALID  in  DATA_W/2/1/1  upstream stream from DMA.
- S_AXIS_TREADY  out  1  upstream ready.
- M_AXIS_TDATA/TKEEP/TLAST/TVALID  out  DATA_W/2/1/1  result stream to DMA.
- M_AXIS_TREADY  in  1  downstream ready.
- eng_tdata/eng_tkeep/eng_tlast  out  DATA_W/2/1  shared feed bus to all engines.
- eng_tvalid  out  NUM_ENG  one-hot valid to the selected engine.
- eng_tready  in  NUM_ENG  per-engine slave ready.
- ret_tdata  in  NUM_ENG*DATA_W  engine result data, packed (engine i at [i*DATA_W +: DATA_W]).
- ret_tkeep  in  NUM_ENG*2  engine result keep, packed.
- ret_tlast/ret_tvalid  in  NUM_ENG  engine result last/valid.
- ret_tready  out  NUM_ENG  one-hot ready to the selected engine.
- eng_resetn  out  NUM_ENG  per-engine active-low soft reset.
- busy  out  1  high in any non-IDLE state.
- cur_op  out  3  latched opcode, 0 when idle.
- out_beats  out  CNT_W  result beats of the last completed packet.
- err_bad_op  out  1  one-cycle pulse on an illegal or header-only packet.
- err_timeout  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset (async assert, sync release): state=IDLE, all eng_resetn=0, all eng_tvalid/ret_tready=0, S_AXIS_TREADY=0, M_AXIS_TVALID=0, busy=0, cur_op=0, out_beats=0, error pulses 0.
- IDLE:
  - S_AXIS_TREADY=1.
  - Header beat = first accepted beat; op = TDATA[2:0].
  - op in 1..NUM_ENG and TLAST=0: latch sel, go to CLEAR.
  - Illegal op with TLAST=0: pulse err_bad_op, go to DISCARD.
  - Any header with TLAST=1: pulse err_bad_op, stay in IDLE.
- CLEAR (exactly 1 cycle):
  - eng_resetn[sel]=0, S_AXIS_TREADY=0.
  - Clear in_done, out_done and the beat counter.
  - Go to STREAM.
- STREAM:
  - eng_resetn[sel]=1; all other engines held in reset.
  - Feed path, combinational, zero latency: eng_t* = S_AXIS_T*; eng_tvalid[sel] = S_AXIS_TVALID & !in_done; S_AXIS_TREADY = eng_tready[sel] & !in_done.
  - Return path, combinational: M_AXIS_T* = ret[sel]; M_AXIS_TVALID = ret_tvalid[sel] & !out_done; ret_tready[sel] = M_AXIS_TREADY & !out_done.
  - Accepted input TLAST sets in_done. Accepted output TLAST sets out_done and copies the counter to out_beats.
  - Counter increments on each accepted M beat and saturates at all-ones.
  - Both directions may finish in the same cycle. Output TLAST before input TLAST is legal: stay in STREAM until in_done.
  - When in_done & out_done: go to IDLE; that engine returns to reset.
- DISCARD:
  - S_AXIS_TREADY=1; beats are dropped.
  - Accepted TLAST returns to IDLE.
- No registered stage in either data path; every handshake is the AXI valid&ready product.
- Reset mid-packet: abandon immediately, apply reset values; no state persists.

Optional Feature:
- Macro LAYER_SEQ_TIMEOUT_EN, enabled:
  - In STREAM, a CNT_W watchdog counts cycles with no accepted beat on either side and clears on any handshake.
  - At all-ones: pulse err_timeout and return the engine to reset.
  - Then go to DISCARD if !in_done, else IDLE.
- Disabled: no watchdog counter; err_timeout tied 0.

Decomposition:
- Package layer_seq_pkg holds:
  - opcode constants OP_CONV2D=1, OP_CHADD=2, OP_MAXPOOL=3, OP_RELU=4;
  - the state enum (IDLE, CLEAR, STREAM, DISCARD);
  - header field positions.
- One natural sub-module, stream_mux_n: NUM_ENG-way combinational return-path mux plus one-hot ready demux.

Test Plan:
- Header 0x1, 9 data beats (TLAST on 9th); engine 0 model echoes 4 beats → eng_resetn[0] low exactly 1 cycle; 9 beats on eng bus; M emits 4 beats with TLAST; out_beats=4; busy falls 1 cycle after the last of both TLASTs.
- Header 0x7, 3 beats → err_bad_op pulses once; no eng_tvalid; TREADY held 1; IDLE after the 3rd beat.
- Header 0x4 with TLAST=1 → err_bad_op; state stays IDLE; eng_resetn stays all 0.
- Engine 2 result TLAST 2 cycles before input TLAST, with random M_AXIS_TREADY/S_AXIS_TVALID stalls → no beats lost or duplicated; M_AXIS_TVALID stays 0 after the output TLAST; IDLE after the input TLAST.
- Assert S_AXIS_ARESETN low mid-STREAM → all outputs at reset values in the same cycle; next header 0x3 processes normally.
- With LAYER_SEQ_TIMEOUT_EN, CNT_W=4, engine ready stuck low → err_timeout after 15 idle cycles; remaining input discarded through TLAST.
